cnt_div_updown: RTL and testbench
=================================

Name: cnt_div_updown

Overview:
- Parametrised synchronous up/down modulo counter with an integrated prescaler. It is the successor to the fixed 4-bit divided-clock counter.
- Counter and prescaler run on the single system clock. Stepping is gated by an internal one-cycle tick (a clock enable), not by a derived clock.
- Adds direction control, parallel load, programmable modulo, terminal-count and wrap indication.
- Sits between the board clock and display/sequencing logic that needs a slow, settable count.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULO, 16, count range 0..MODULO-1. Legal range is 2..2^WIDTH.
- DIV, 50, prescaler ratio: the counter steps once every DIV enabled clk cycles. Must be >= 1.
- Local: PW = max(1, clog2(DIV)), the prescaler width.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable. Low freezes both the prescaler and the counter.
- up_dn  input  1  1 = count up, 0 = count down. Sampled on tick cycles.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value for load.
- out  output  WIDTH  registered count value.
- tick  output  1  combinational; high in cycles where the counter steps at the next edge.
- tc  output  1  combinational terminal count: (up_dn && out==MODULO-1) || (!up_dn && out==0).
- wrap  output  1  registered one-cycle pulse, high in the cycle after the counter wrapped.
- ovf  output  1  sticky overflow flag. See Optional Feature.

Behaviour:
- Reset (rst high at a clk edge): out=0, prescaler=0, wrap=0, ovf=0. rst overrides load and en.
- Because tick and tc are combinational, during and just after reset: tick = en && (DIV==1). tc = !up_dn (out is 0).
- Prescaler: pre counts 0..DIV-1 while en=1 and wraps to 0 after DIV-1. It holds while en=0.
- tick = en && (pre == DIV-1). With DIV=1, tick = en.
- Step on a tick edge, up (up_dn=1): out = (out==MODULO-1) ? 0 : out+1.
- Step on a tick edge, down (up_dn=0): out = (out==0) ? MODULO-1 : out-1.
- wrap is set to 1 on the edge where out goes MODULO-1→0 (up) or 0→MODULO-1 (down). Otherwise wrap is 0.
- Load has priority over step, regardless of en or tick.
  - out = (load_val >= MODULO) ? MODULO-1 : load_val (saturating clamp).
  - pre is cleared to 0, so the first step after a load occurs DIV enabled cycles later.
  - wrap = 0 on a load edge.
- A load coinciding with tick: the load wins and no step occurs.
- A direction change takes effect on the next tick only. Mid-period changes of up_dn do not disturb pre.
- Arithmetic is WIDTH bits. out never holds a value >= MODULO.
- Step latency: out changes on the clk edge at which tick=1. Steady-state period is exactly DIV cycles with en=1.
- rst asserted mid-period discards the partial prescale. After rst deasserts, the first tick occurs after DIV enabled cycles.

Optional Feature:
- Macro: CNT_OVF_STICKY_EN.
- Defined: ovf is set to 1 on any edge where wrap is set. It stays 1 until rst or load, both of which clear it. If a load coincides with a wrap-causing tick, the load wins and ovf is cleared.
- Not defined: ovf is constant 0 and no flop is inferred. The port list is unchanged.

Test Plan:
- WIDTH=4, MODULO=16, DIV=4, en=1, up_dn=1 after reset -> tick every 4th cycle. out steps 0,1,...,15,0. wrap pulses once after 15→0. tc high while out=15.
- MODULO=10, DIV=1, up_dn=0 from reset -> out sequence 0,9,8,...,0,9. wrap pulses after 0→9. tc high while out=0.
- DIV=4: en low for 3 cycles with pre=2 -> out and pre hold. tick first rises on the 2nd enabled cycle after en returns high.
- MODULO=10: load=1, load_val=13 -> out=9 and pre=0. Load asserted in a tick cycle with load_val=5 -> out=5 with no step.
- rst asserted for 1 cycle mid-count (out=7, pre=2) -> next edge gives out=0, pre=0, wrap=0. First step occurs after DIV enabled cycles.
- With CNT_OVF_STICKY_EN defined: run past one wrap -> ovf=1 and holds. A load -> ovf=0. Without the macro, ovf=0 throughout.

Source files
------------

// File: rtl/cnt_div_updown.sv
// Up/down modulo counter stepped by an internal prescaler tick, with parallel load,
// terminal count and wrap pulse. Define CNT_OVF_STICKY_EN for the sticky overflow flag.
module cnt_div_updown #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16,
    parameter int DIV    = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULO - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);

    logic [PW-1:0]    pre;
    logic             at_top;
    logic             at_bottom;
    logic             step_wraps;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;

    assign at_top     = (out == TOP);
    assign at_bottom  = (out == '0);
    assign tick       = en && (pre == PRE_LAST);
    assign tc         = up_dn ? at_top : at_bottom;
    assign step_wraps = up_dn ? at_top : at_bottom;

    // The load compare is one bit wider so MODULO == 2^WIDTH never clamps.
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? TOP : load_val;

    always_comb begin
        step_val = out;
        if (up_dn) begin
            step_val = at_top ? '0 : out + 1'b1;
        end else begin
            step_val = at_bottom ? TOP : out - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            out  <= load_clamped;
            wrap <= 1'b0;
        end else if (tick) begin
            out  <= step_val;
            wrap <= step_wraps;
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef CNT_OVF_STICKY_EN
    logic ovf_q;

    // Load clears the flag even when it coincides with a wrap-causing tick.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            ovf_q <= 1'b0;
        end else if (tick && step_wraps) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_div_updown.sv
// Directed bench for cnt_div_updown: three instances cover DIV=4 up counting,
// DIV=1 down counting, and load/reset behaviour with MODULO=10.
module tb_cnt_div_updown;

`ifdef CNT_OVF_STICKY_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance a: WIDTH=4, MODULO=16, DIV=4
    logic       a_rst, a_en, a_up, a_load;
    logic [3:0] a_lv, a_out;
    logic       a_tick, a_tc, a_wrap, a_ovf;
    // Instance b: WIDTH=4, MODULO=10, DIV=1
    logic       b_rst, b_en, b_up, b_load;
    logic [3:0] b_lv, b_out;
    logic       b_tick, b_tc, b_wrap, b_ovf;
    // Instance c: WIDTH=4, MODULO=10, DIV=4
    logic       c_rst, c_en, c_up, c_load;
    logic [3:0] c_lv, c_out;
    logic       c_tick, c_tc, c_wrap, c_ovf;

    cnt_div_updown #(.WIDTH(4), .MODULO(16), .DIV(4)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .load(a_load), .load_val(a_lv),
        .out(a_out), .tick(a_tick), .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf)
    );
    cnt_div_updown #(.WIDTH(4), .MODULO(10), .DIV(1)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .load(b_load), .load_val(b_lv),
        .out(b_out), .tick(b_tick), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf)
    );
    cnt_div_updown #(.WIDTH(4), .MODULO(10), .DIV(4)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .up_dn(c_up), .load(c_load), .load_val(c_lv),
        .out(c_out), .tick(c_tick), .tc(c_tc), .wrap(c_wrap), .ovf(c_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int eo;

    initial begin
        a_rst = 1; a_en = 1; a_up = 1; a_load = 0; a_lv = '0;
        b_rst = 1; b_en = 1; b_up = 0; b_load = 0; b_lv = '0;
        c_rst = 1; c_en = 1; c_up = 1; c_load = 0; c_lv = '0;
        step();

        // Reset state
        check("a_rst_out",  a_out,  0);
        check("a_rst_wrap", a_wrap, 0);
        check("a_rst_ovf",  a_ovf,  0);
        check("a_rst_tick", a_tick, 0);
        check("a_rst_tc",   a_tc,   0);
        check("b_rst_tick", b_tick, 1);
        check("b_rst_tc",   b_tc,   1);
        check("c_rst_out",  c_out,  0);

        a_rst = 0; b_en = 0; c_en = 0;

        // a: up count, DIV=4, one full lap plus a little
        for (int n = 0; n <= 70; n++) begin
            if (n > 0) step();
            eo = (n / 4) % 16;
            check("a_run_out",  a_out,  eo);
            check("a_run_tick", a_tick, (n % 4) == 3);
            check("a_run_tc",   a_tc,   eo == 15);
            check("a_run_wrap", a_wrap, (n > 0) && (n % 64 == 0));
            check("a_run_ovf",  a_ovf,  OVF_ON && (n >= 64));
        end

        // a: hold with en low at pre=2, out=1
        a_en = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("a_hold_out",  a_out,  1);
            check("a_hold_tick", a_tick, 0);
        end
        a_en = 1;
        #1;
        check("a_resume_tick0", a_tick, 0);
        step();
        check("a_resume_tick1", a_tick, 1);
        check("a_resume_out1",  a_out,  1);
        step();
        check("a_resume_out2",  a_out,  2);
        check("a_resume_tick2", a_tick, 0);

        // b: down count, MODULO=10, DIV=1
        b_en = 1; b_rst = 1;
        step();
        b_rst = 0;
        for (int n = 0; n <= 21; n++) begin
            if (n > 0) step();
            eo = (10 - (n % 10)) % 10;
            check("b_run_out",  b_out,  eo);
            check("b_run_tick", b_tick, 1);
            check("b_run_tc",   b_tc,   eo == 0);
            check("b_run_wrap", b_wrap, (n % 10) == 1);
            check("b_run_ovf",  b_ovf,  OVF_ON && (n >= 1));
        end
        b_en = 0;

        // c: reach out=7, pre=2, then reset mid-period
        c_en = 1; c_rst = 1;
        step();
        c_rst = 0;
        for (int n = 1; n <= 30; n++) step();
        check("c_pre_rst_out", c_out, 7);
        c_rst = 1;
        step();
        c_rst = 0;
        check("c_mid_rst_out",  c_out,  0);
        check("c_mid_rst_wrap", c_wrap, 0);
        check("c_mid_rst_tick", c_tick, 0);
        check("c_mid_rst_tc",   c_tc,   0);
        for (int m = 1; m <= 42; m++) begin
            step();
            check("c_run_out",  c_out,  (m / 4) % 10);
            check("c_run_tick", c_tick, (m % 4) == 3);
            check("c_run_wrap", c_wrap, m == 40);
            check("c_run_ovf",  c_ovf,  OVF_ON && (m >= 40));
        end

        // c: clamped load clears pre, wrap and ovf
        c_load = 1; c_lv = 4'd13;
        step();
        c_load = 0;
        check("c_load_out",  c_out,  9);
        check("c_load_wrap", c_wrap, 0);
        check("c_load_ovf",  c_ovf,  0);
        check("c_load_tc",   c_tc,   1);
        check("c_load_tick", c_tick, 0);
        step();
        check("c_post1_tick", c_tick, 0);
        step();
        check("c_post2_tick", c_tick, 0);
        step();
        check("c_post3_tick", c_tick, 1);
        check("c_post3_out",  c_out,  9);

        // c: load in a tick cycle wins over the wrapping step
        c_load = 1; c_lv = 4'd5;
        step();
        c_load = 0;
        check("c_ltick_out",  c_out,  5);
        check("c_ltick_wrap", c_wrap, 0);
        check("c_ltick_ovf",  c_ovf,  0);
        check("c_ltick_tick", c_tick, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
